// File: rtl/ddr_port_arbiter.sv
// Round-robin owner of the shared DDR read/write path: grants one requester at a time,
// forwards its command to the path and routes the completion pulse back to it.
module ddr_port_arbiter #(
  parameter int NREQ          = 3,
  parameter int ADDR_WIDTH    = 30,
  parameter int DATA_NUM_BITS = 20,
  parameter int GW            = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          init_calib_complete_i,
  input  logic [NREQ-1:0]               req_i,
  input  logic [NREQ-1:0]               cmd_en_i,
  input  logic [NREQ-1:0]               cmd_wr_i,
  input  logic [NREQ*DATA_NUM_BITS-1:0] burst_num_i,
  input  logic [NREQ*ADDR_WIDTH-1:0]    start_addr_i,
  output logic [NREQ-1:0]               ack_o,
  output logic [NREQ-1:0]               done_o,
  output logic [GW-1:0]                 grant_idx_o,
  output logic                          busy_o,
  output logic                          rd_en_o,
  output logic                          wr_en_o,
  output logic [DATA_NUM_BITS-1:0]      burst_num_o,
  output logic [ADDR_WIDTH-1:0]         start_addr_o,
  input  logic                          rd_ddr_done_i,
  input  logic                          wr_ddr_done_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t                   r_state, w_state;
  logic [GW-1:0]            r_ptr, w_ptr;
  logic [GW-1:0]            r_gidx, w_gidx;
  logic [NREQ-1:0]          r_ack, w_ack;
  logic [NREQ-1:0]          r_done, w_done;
  logic                     r_busy, w_busy;
  logic                     r_rd_en, w_rd_en;
  logic                     r_wr_en, w_wr_en;
  logic                     r_is_wr, w_is_wr;
  logic [DATA_NUM_BITS-1:0] r_burst, w_burst;
  logic [ADDR_WIDTH-1:0]    r_addr, w_addr;

  logic                     w_found;
  logic [GW-1:0]            w_win;
  logic [NREQ-1:0]          w_win_oh;
  int                       w_idx;
  logic [NREQ-1:0]          w_g_oh;
  logic                     w_sel_req, w_sel_en, w_sel_wr;
  logic [DATA_NUM_BITS-1:0] w_sel_burst;
  logic [ADDR_WIDTH-1:0]    w_sel_addr;
  logic                     w_match;

  // Search for the first requester after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      else               w_idx = w_idx;
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && (k == w_idx) && req_i[k]) begin
          w_found     = 1'b1;
          w_win       = GW'(k);
          w_win_oh[k] = 1'b1;
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  // Pick out the current owner's request and command fields; other requesters are invisible.
  always_comb begin
    w_g_oh      = '0;
    w_sel_req   = 1'b0;
    w_sel_en    = 1'b0;
    w_sel_wr    = 1'b0;
    w_sel_burst = '0;
    w_sel_addr  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_gidx == GW'(k)) begin
        w_g_oh[k]   = 1'b1;
        w_sel_req   = req_i[k];
        w_sel_en    = cmd_en_i[k];
        w_sel_wr    = cmd_wr_i[k];
        w_sel_burst = burst_num_i[k*DATA_NUM_BITS +: DATA_NUM_BITS];
        w_sel_addr  = start_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        w_g_oh[k] = 1'b0;
      end
    end
    w_match = r_is_wr ? wr_ddr_done_i : rd_ddr_done_i;
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_gidx  = r_gidx;
    w_ack   = r_ack;
    w_busy  = r_busy;
    w_done  = '0;
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_is_wr = r_is_wr;
    w_burst = r_burst;
    w_addr  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (init_calib_complete_i && w_found) begin
          w_state = S_GRANT;
          w_ptr   = w_win;
          w_gidx  = w_win;
          w_ack   = w_win_oh;
          w_busy  = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_sel_en) begin
          w_is_wr = w_sel_wr;
          w_burst = w_sel_burst;
          w_addr  = w_sel_addr;
          // A zero-length burst completes locally without touching the path.
          if (w_sel_burst == '0) begin
            w_done = w_g_oh;
          end else begin
            w_rd_en = ~w_sel_wr;
            w_wr_en = w_sel_wr;
            w_state = S_BUSY;
          end
        end else if (!w_sel_req) begin
          w_state = S_IDLE;
          w_ack   = '0;
          w_busy  = 1'b0;
        end else begin
          w_state = S_GRANT;
        end
      end
      S_BUSY: begin
        if (w_match) begin
          w_done = w_g_oh;
          if (w_sel_req) begin
            w_state = S_GRANT;
          end else begin
            w_state = S_IDLE;
            w_ack   = '0;
            w_busy  = 1'b0;
          end
        end else begin
          w_state = S_BUSY;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_ack   = '0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_ptr   <= GW'(NREQ - 1);
      r_gidx  <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_is_wr <= 1'b0;
      r_burst <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_gidx  <= w_gidx;
      r_ack   <= w_ack;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_rd_en <= w_rd_en;
      r_wr_en <= w_wr_en;
      r_is_wr <= w_is_wr;
      r_burst <= w_burst;
      r_addr  <= w_addr;
    end
  end

  assign ack_o        = r_ack;
  assign done_o       = r_done;
  assign grant_idx_o  = r_gidx;
  assign busy_o       = r_busy;
  assign rd_en_o      = r_rd_en;
  assign wr_en_o      = r_wr_en;
  assign burst_num_o  = r_burst;
  assign start_addr_o = r_addr;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: one task per scenario, inline comparisons
// against hand-computed values.
module tb_ddr_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 30;
  localparam int DW   = 20;
  localparam int GW   = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             calib;
  logic [NREQ-1:0]  req, cmd_en, cmd_wr;
  logic [NREQ*DW-1:0] burst;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]  ack, done;
  logic [GW-1:0]    gidx;
  logic             busy, rd_en, wr_en;
  logic [DW-1:0]    burst_o;
  logic [AW-1:0]    addr_o;
  logic             rd_done, wr_done;

  int total = 0;
  int bad   = 0;

  ddr_port_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_NUM_BITS(DW), .GW(GW)) dut (
    .clk_i(clk), .rstn_i(rstn), .init_calib_complete_i(calib),
    .req_i(req), .cmd_en_i(cmd_en), .cmd_wr_i(cmd_wr),
    .burst_num_i(burst), .start_addr_i(addr),
    .ack_o(ack), .done_o(done), .grant_idx_o(gidx), .busy_o(busy),
    .rd_en_o(rd_en), .wr_en_o(wr_en), .burst_num_o(burst_o), .start_addr_o(addr_o),
    .rd_ddr_done_i(rd_done), .wr_ddr_done_i(wr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; calib = 1'b1; req = '0; cmd_en = '0; cmd_wr = '0;
    burst = '0; addr = '0; rd_done = 1'b0; wr_done = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; calib = 1'b0; req = '0; cmd_en = '0; cmd_wr = '0;
    burst = '0; addr = '0; rd_done = 1'b0; wr_done = 1'b0;
    tick();
    total++;
    if ({ack, done, busy, rd_en, wr_en} !== 9'd0) begin
      $display("FAIL reset_ctl: got %b want 0", {ack, done, busy, rd_en, wr_en}); bad++;
    end
    total++;
    if ({burst_o, addr_o, gidx} !== 52'd0) begin
      $display("FAIL reset_data: got %h want 0", {burst_o, addr_o, gidx}); bad++;
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_calib_gate();
    calib = 1'b0; req = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ack !== 3'b000) begin $display("FAIL calib_block: cyc %0d got %b want 000", i, ack); bad++; end
    end
    calib = 1'b1;
    tick();
    total++;
    if (ack !== 3'b010 || gidx !== 2'd1 || busy !== 1'b1) begin
      $display("FAIL calib_grant: ack=%b idx=%0d busy=%b want 010/1/1", ack, gidx, busy); bad++;
    end
    req = 3'b000;
    tick();
    total++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      $display("FAIL calib_release: ack=%b busy=%b want 000/0", ack, busy); bad++;
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b001;
    tick();
    total++;
    if (ack !== 3'b001 || gidx !== 2'd0) begin $display("FAIL read_grant: ack=%b idx=%0d want 001/0", ack, gidx); bad++; end
    cmd_en = 3'b001; cmd_wr = 3'b000;
    burst[0 +: DW] = 20'd16; addr[0 +: AW] = 30'h100;
    tick();
    cmd_en = 3'b000;
    total++;
    if (rd_en !== 1'b1 || wr_en !== 1'b0 || burst_o !== 20'd16 || addr_o !== 30'h100) begin
      $display("FAIL read_issue: rd=%b wr=%b burst=%0d addr=%h want 1/0/16/100", rd_en, wr_en, burst_o, addr_o); bad++;
    end
    tick();
    total++;
    if (rd_en !== 1'b0) begin $display("FAIL read_pulse_width: rd=%b want 0", rd_en); bad++; end
    for (int i = 0; i < 18; i++) tick();
    total++;
    if (done !== 3'b000 || busy !== 1'b1) begin $display("FAIL read_wait: done=%b busy=%b want 000/1", done, busy); bad++; end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++;
    if (done !== 3'b001 || ack !== 3'b001) begin $display("FAIL read_done: done=%b ack=%b want 001/001", done, ack); bad++; end
    req = 3'b000;
    tick();
    total++;
    if (done !== 3'b000 || ack !== 3'b000 || busy !== 1'b0) begin
      $display("FAIL read_release: done=%b ack=%b busy=%b want 000/000/0", done, ack, busy); bad++;
    end
  endtask

  task automatic test_round_robin();
    logic [GW-1:0] exp_idx [4];
    exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd2; exp_idx[3] = 2'd0;
    do_reset();
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      int g;
      logic [NREQ-1:0] oh;
      g  = int'(exp_idx[n]);
      oh = '0;
      oh[g] = 1'b1;
      tick();
      total++;
      if (gidx !== exp_idx[n] || ack !== oh) begin
        $display("FAIL rr_grant: turn %0d idx=%0d ack=%b want %0d/%b", n, gidx, ack, exp_idx[n], oh); bad++;
      end
      cmd_en[g] = 1'b1; cmd_wr[g] = 1'b1;
      burst[g*DW +: DW] = 20'd4; addr[g*AW +: AW] = 30'h1000 + AW'(g);
      tick();
      cmd_en = '0;
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      total++;
      if (done !== oh) begin $display("FAIL rr_done: turn %0d done=%b want %b", n, done, oh); bad++; end
      req[g] = 1'b0;
      tick();
      req = 3'b111;
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_chain();
    do_reset();
    req = 3'b100;
    tick();
    total++;
    if (ack !== 3'b100 || gidx !== 2'd2) begin $display("FAIL chain_grant: ack=%b idx=%0d want 100/2", ack, gidx); bad++; end
    cmd_en = 3'b100; cmd_wr = 3'b100;
    burst[2*DW +: DW] = 20'd8; addr[2*AW +: AW] = 30'h2000;
    tick();
    cmd_en = '0;
    total++;
    if (wr_en !== 1'b1 || rd_en !== 1'b0 || addr_o !== 30'h2000) begin
      $display("FAIL chain_wr_issue: wr=%b rd=%b addr=%h want 1/0/2000", wr_en, rd_en, addr_o); bad++;
    end
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++;
    if (done !== 3'b000 || ack !== 3'b100) begin $display("FAIL chain_stray_rd: done=%b ack=%b want 000/100", done, ack); bad++; end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (done !== 3'b100 || ack !== 3'b100) begin $display("FAIL chain_done1: done=%b ack=%b want 100/100", done, ack); bad++; end
    cmd_en = 3'b101; cmd_wr = 3'b001;
    burst[2*DW +: DW] = 20'd3; addr[2*AW +: AW] = 30'h3000;
    burst[0 +: DW]    = 20'd9; addr[0 +: AW]    = 30'h0BAD;
    tick();
    cmd_en = '0;
    total++;
    if (rd_en !== 1'b1 || wr_en !== 1'b0 || burst_o !== 20'd3 || addr_o !== 30'h3000 || ack !== 3'b100) begin
      $display("FAIL chain_rd_issue: rd=%b wr=%b burst=%0d addr=%h ack=%b want 1/0/3/3000/100", rd_en, wr_en, burst_o, addr_o, ack); bad++;
    end
    req = 3'b000;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (done !== 3'b000 || busy !== 1'b1) begin $display("FAIL chain_stray_wr: done=%b busy=%b want 000/1", done, busy); bad++; end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++;
    if (done !== 3'b100 || ack !== 3'b000 || busy !== 1'b0) begin
      $display("FAIL chain_drop_in_busy: done=%b ack=%b busy=%b want 100/000/0", done, ack, busy); bad++;
    end
    tick();
    total++;
    if (done !== 3'b000) begin $display("FAIL chain_done_width: done=%b want 000", done); bad++; end
  endtask

  task automatic test_zero_burst();
    do_reset();
    req = 3'b010;
    tick();
    total++;
    if (ack !== 3'b010) begin $display("FAIL zero_grant: ack=%b want 010", ack); bad++; end
    cmd_en = 3'b010; cmd_wr = 3'b010;
    burst[DW +: DW] = 20'd0; addr[AW +: AW] = 30'h40;
    tick();
    cmd_en = '0;
    total++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0 || done !== 3'b010 || ack !== 3'b010 || addr_o !== 30'h40) begin
      $display("FAIL zero_burst: wr=%b rd=%b done=%b ack=%b addr=%h want 0/0/010/010/40", wr_en, rd_en, done, ack, addr_o); bad++;
    end
    tick();
    total++;
    if (done !== 3'b000 || busy !== 1'b1 || wr_en !== 1'b0) begin
      $display("FAIL zero_after: done=%b busy=%b wr=%b want 000/1/0", done, busy, wr_en); bad++;
    end
    req = 3'b000;
    tick();
    total++;
    if (ack !== 3'b000 || busy !== 1'b0) begin $display("FAIL zero_release: ack=%b busy=%b want 000/0", ack, busy); bad++; end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req = 3'b001;
    tick();
    cmd_en = 3'b001; cmd_wr = 3'b000;
    burst[0 +: DW] = 20'd5; addr[0 +: AW] = 30'h500;
    tick();
    cmd_en = '0;
    tick();
    total++;
    if (busy !== 1'b1 || burst_o !== 20'd5) begin $display("FAIL rst_setup: busy=%b burst=%0d want 1/5", busy, burst_o); bad++; end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({ack, done, busy, rd_en, wr_en, gidx} !== 11'd0 || burst_o !== 20'd0 || addr_o !== 30'd0) begin
      $display("FAIL rst_async: ctl=%b burst=%0d addr=%h want 0", {ack, done, busy, rd_en, wr_en, gidx}, burst_o, addr_o); bad++;
    end
    req = 3'b000;
    tick();
    rstn = 1'b1;
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    total++;
    if (done !== 3'b000 || busy !== 1'b0) begin $display("FAIL rst_late_done: done=%b busy=%b want 000/0", done, busy); bad++; end
    req = 3'b111;
    tick();
    total++;
    if (ack !== 3'b001 || gidx !== 2'd0) begin $display("FAIL rst_first_grant: ack=%b idx=%0d want 001/0", ack, gidx); bad++; end
    req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_single_read();
    test_round_robin();
    test_chain();
    test_zero_burst();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single DDR read/write path among NREQ requesters: inner-product parameter fetch, export writer, conv prepare writer.
- Grants the port round-robin and forwards the granted requester's command to the DDR read/write path.
- Routes the path's completion pulses back to the granted requester.
- Replaces ad-hoc req/ack gating and enable muxing at the fc top level with one sequenced owner of the port.

Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 30, DDR start-address width
- DATA_NUM_BITS, 20, burst-count width
- GW, 2, grant-index width; must satisfy 2^GW >= NREQ

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- init_calib_complete_i  in  1  DDR calibration done; no grant is issued while low
- req_i  in  NREQ  per-requester port request, level, held for the whole ownership
- cmd_en_i  in  NREQ  per-requester command strobe, 1-cycle pulse
- cmd_wr_i  in  NREQ  per-requester command type: 1=write, 0=read
- burst_num_i  in  NREQ*DATA_NUM_BITS  per-requester burst count, requester k at slice [k*DATA_NUM_BITS +: DATA_NUM_BITS]
- start_addr_i  in  NREQ*ADDR_WIDTH  per-requester start address, same slicing rule
- ack_o  out  NREQ  one-hot grant, registered
- done_o  out  NREQ  per-requester command-complete pulse, registered
- grant_idx_o  out  GW  index of current owner; valid while busy_o=1
- busy_o  out  1  port owned
- rd_en_o  out  1  read command pulse to path
- wr_en_o  out  1  write command pulse to path
- burst_num_o  out  DATA_NUM_BITS  latched burst count
- start_addr_o  out  ADDR_WIDTH  latched start address
- rd_ddr_done_i  in  1  path read complete
- wr_ddr_done_i  in  1  path write complete

Behaviour:
- Reset: async on rstn_i=0. All outputs 0, state=IDLE, round-robin pointer=NREQ-1 so requester 0 is searched first.
- IDLE:
  - If init_calib_complete_i=1 and |req_i, pick the first requesting index searching from pointer+1, wrapping modulo NREQ.
  - Next cycle: ack_o one-hot, busy_o=1, grant_idx_o set, pointer := winner, go to GRANT.
  - Latency: req to ack is exactly 1 cycle.
- GRANT:
  - If cmd_en_i[g]=1: latch cmd_wr_i[g], burst_num_i[g] and start_addr_i[g] into burst_num_o and start_addr_o. Next cycle pulse rd_en_o or wr_en_o for exactly 1 cycle, then go to BUSY.
  - Else if req_i[g]=0: drop ack_o and busy_o next cycle and go to IDLE.
  - cmd_en_i from non-granted requesters is ignored at all times.
- Zero burst: if the latched burst count is 0, issue no path command. Pulse done_o[g] the next cycle and stay in GRANT.
- BUSY:
  - Wait for the done input matching the latched type: rd_ddr_done_i for a read, wr_ddr_done_i for a write. The mismatched done is ignored.
  - On match: done_o[g] pulses 1 cycle later; return to GRANT, ack held.
  - A requester may chain multiple commands within one ownership.
  - cmd_en_i[g] asserted while in BUSY is ignored; the requester must wait for done_o.
- req_i[g] falling while in BUSY: the in-flight command completes, done_o[g] still pulses, then the block releases directly to IDLE.
- init_calib_complete_i falling: an ownership already granted continues; no new grants are issued.
- Simultaneous requests: a single winner per arbitration, strictly rotating. A continuously requesting requester waits at most NREQ-1 ownerships.
- burst_num_o and start_addr_o hold their last value when not in use.
- ack_o never has more than one bit set; rd_en_o and wr_en_o are never both 1.
- Reset asserted mid-BUSY: outputs clear immediately; any path done arriving after reset release is ignored because the block is in IDLE.

Test Plan:
- Calibration gate: calib=0, req_i=3'b010 for 5 cycles -> ack_o=0. Raise calib -> ack_o=3'b010 one cycle later, grant_idx_o=1.
- Single read: requester 0 strobes cmd_en with wr=0, burst=16, addr=0x100 -> one rd_en_o pulse with burst_num_o=16 and start_addr_o=0x100. rd_ddr_done_i after 20 cycles -> done_o=3'b001 one cycle later. Drop req -> ack_o=0 and busy_o=0 next cycle.
- Round-robin: req_i=3'b111 held, each owner does one command then releases -> grants in order 0,1,2,0.
- Chained commands and wrong done: requester 2 issues a write, then a read, without dropping req. A stray rd_ddr_done_i during the write is ignored. Exactly two done_o[2] pulses are produced and ack_o[2] is held throughout.
- Zero burst: burst=0 write -> no wr_en_o, done_o pulse 1 cycle after the strobe.
- Reset mid-BUSY: rstn_i low during a read -> all outputs 0 immediately. After release, a late rd_ddr_done_i produces no done_o. Next grant with all requesting goes to requester 0.
